// File: rtl/serial_word_rx_if.sv
// Stream-side bundle of the serial word receiver: frame strobe, sample enable,
// serial data in, and the reassembled word / index / checksum / status out.
interface serial_word_rx_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 16
);
  localparam int NW = $clog2(WORDS);

  logic             start;
  logic             en;
  logic             rx;
  logic [WIDTH-1:0] WORD;
  logic [NW-1:0]    NOM;
  logic             VLD;
  logic             FRM;
  logic [WIDTH-1:0] CHK;
  logic             BUSY;

  modport master (
    output start, en, rx,
    input  WORD, NOM, VLD, FRM, CHK, BUSY
  );

  modport slave (
    input  start, en, rx,
    output WORD, NOM, VLD, FRM, CHK, BUSY
  );
endinterface

// File: rtl/serial_word_rx.sv
// Reassembles LSB-first serial words into WIDTH-bit words, numbers them within a
// frame of WORDS words, and produces the XOR checksum of each completed frame.
module serial_word_rx #(
  parameter int WIDTH = 4,   // must be >= 2
  parameter int WORDS = 16   // must be >= 2
) (
  input  logic            hit,
  input  logic            clr,
  serial_word_rx_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int NW = $clog2(WORDS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [NW-1:0] LAST_WORD = NW'(WORDS - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state, state_d;

  // Only the WIDTH-1 already-received bits are stored; the MSB arrives on rx
  // in the cycle the word completes.
  logic [WIDTH-2:0] part;
  logic [BW-1:0]    bitcnt;
  logic [NW-1:0]    wordcnt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] word_next;

  logic [WIDTH-1:0] word_q;
  logic [NW-1:0]    nom_q;
  logic [WIDTH-1:0] chk_q;
  logic             vld_q;
  logic             frm_q;

  logic capture;     // rx is bit 0 of word 0 of a new frame
  logic shift;       // rx is the next bit of the current frame
  logic word_done;
  logic frame_done;

  assign word_next = {bus.rx, part};

  always_ff @(posedge hit or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d    = state;
    capture    = 1'b0;
    shift      = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && bus.start) begin
          capture = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.en) begin
          // start wins even on the final bit of a frame: that word is dropped
          if (bus.start) begin
            capture = 1'b1;
          end else begin
            shift = 1'b1;
            if (bitcnt == LAST_BIT) begin
              word_done = 1'b1;
              if (wordcnt == LAST_WORD) begin
                frame_done = 1'b1;
                state_d    = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hit or negedge clr) begin
    if (!clr) begin
      part    <= '0;
      bitcnt  <= '0;
      wordcnt <= '0;
      xr      <= '0;
      word_q  <= '0;
      nom_q   <= '0;
      chk_q   <= '0;
      vld_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      // NOTE: pulses default low on every edge and are raised only by a
      // completing word, so each lasts exactly one cycle, even if en drops.
      vld_q <= 1'b0;
      frm_q <= 1'b0;
      if (capture) begin
        part    <= word_next[WIDTH-1:1];
        bitcnt  <= BW'(1);
        wordcnt <= '0;
        xr      <= '0;
      end else if (shift) begin
        part <= word_next[WIDTH-1:1];
        if (word_done) begin
          bitcnt  <= '0;
          wordcnt <= wordcnt + NW'(1);
          xr      <= xr ^ word_next;
          word_q  <= word_next;
          nom_q   <= wordcnt;
          vld_q   <= 1'b1;
          if (frame_done) begin
            chk_q <= xr ^ word_next;
            frm_q <= 1'b1;
          end
        end else begin
          bitcnt <= bitcnt + BW'(1);
        end
      end
    end
  end

  assign bus.WORD = word_q;
  assign bus.NOM  = nom_q;
  assign bus.VLD  = vld_q;
  assign bus.FRM  = frm_q;
  assign bus.CHK  = chk_q;
  assign bus.BUSY = (state == RECV);

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: reset, single word, full frames, pause,
// back-to-back frames, restart, start-priority corner and asynchronous reset.
module tb_serial_word_rx;

  logic hit;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_word_rx_if #(.WIDTH(4), .WORDS(16)) bus ();

  serial_word_rx #(.WIDTH(4), .WORDS(16)) dut (
    .hit (hit),
    .clr (clr),
    .bus (bus)
  );

  initial hit = 1'b0;
  always #5 hit = ~hit;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, take the rising edge, sample 1 time unit later.
  task automatic send_bit(input logic s, input logic e, input logic b);
    bus.start = s;
    bus.en    = e;
    bus.rx    = b;
    @(posedge hit);
    #1;
  endtask

  function automatic logic [3:0] pat_word(input int pat, input int w);
    case (pat)
      1:       return 4'h5;
      2:       return (w == 0) ? 4'h9 : 4'(w);
      default: return 4'(w);
    endcase
  endfunction

  task automatic test_reset();
    clr       = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.rx    = 1'b0;
    repeat (3) @(posedge hit);
    #1;
    clr = 1'b1;
    #1;
    n_checks++;
    if (bus.WORD !== 4'h0) begin n_fail++; $display("FAIL reset WORD: got %h want 0", bus.WORD); end
    n_checks++;
    if (bus.NOM !== 4'h0) begin n_fail++; $display("FAIL reset NOM: got %0d want 0", bus.NOM); end
    n_checks++;
    if (bus.CHK !== 4'h0) begin n_fail++; $display("FAIL reset CHK: got %h want 0", bus.CHK); end
    n_checks++;
    if (bus.VLD !== 1'b0) begin n_fail++; $display("FAIL reset VLD: got %b want 0", bus.VLD); end
    n_checks++;
    if (bus.FRM !== 1'b0) begin n_fail++; $display("FAIL reset FRM: got %b want 0", bus.FRM); end
    n_checks++;
    if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset BUSY: got %b want 0", bus.BUSY); end
  endtask

  task automatic test_single_word();
    logic [3:0] w = 4'hA;
    for (int b = 0; b < 4; b++) begin
      send_bit(b == 0, 1'b1, w[b]);
      if (b < 3) begin
        n_checks++;
        if (bus.VLD !== 1'b0 || bus.BUSY !== 1'b1) begin
          n_fail++;
          $display("FAIL single bit %0d: VLD=%b BUSY=%b want VLD=0 BUSY=1", b, bus.VLD, bus.BUSY);
        end
      end
    end
    n_checks++;
    if (bus.WORD !== 4'hA || bus.NOM !== 4'd0 || bus.VLD !== 1'b1 || bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL single word: WORD=%h NOM=%0d VLD=%b BUSY=%b want WORD=a NOM=0 VLD=1 BUSY=1",
               bus.WORD, bus.NOM, bus.VLD, bus.BUSY);
    end
    send_bit(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.VLD !== 1'b0 || bus.WORD !== 4'hA) begin
      n_fail++;
      $display("FAIL single hold: VLD=%b WORD=%h want VLD=0 WORD=a", bus.VLD, bus.WORD);
    end
  endtask

  // One complete frame of pattern pat starting with start on bit 0 of word 0.
  // Optionally pauses en for pause_len cycles before bit 2 of word pause_word.
  task automatic run_frame(input int pat, input int pause_word, input int pause_len, input string tag);
    int         vld_cnt = 0;
    int         frm_cnt = 0;
    int         frm_at  = -1;
    int         edge_n  = 0;
    logic [3:0] chk_exp = 4'h0;
    logic [3:0] w;
    for (int wi = 0; wi < 16; wi++) begin
      w       = pat_word(pat, wi);
      chk_exp = chk_exp ^ w;
      for (int b = 0; b < 4; b++) begin
        if (wi == pause_word && b == 2) begin
          for (int p = 0; p < pause_len; p++) begin
            send_bit(1'b0, 1'b0, ~w[b]);
            edge_n++;
            n_checks++;
            if (bus.VLD !== 1'b0 || bus.FRM !== 1'b0 || bus.BUSY !== 1'b1) begin
              n_fail++;
              $display("FAIL %s pause %0d: VLD=%b FRM=%b BUSY=%b want 0 0 1", tag, p, bus.VLD, bus.FRM, bus.BUSY);
            end
          end
        end
        send_bit(wi == 0 && b == 0, 1'b1, w[b]);
        edge_n++;
        if (bus.VLD === 1'b1) vld_cnt++;
        if (bus.FRM === 1'b1) begin frm_cnt++; frm_at = edge_n; end
        if (b == 3) begin
          n_checks++;
          if ({bus.VLD, bus.FRM, bus.NOM, bus.WORD} !== {1'b1, (wi == 15), 4'(wi), w}) begin
            n_fail++;
            $display("FAIL %s word %0d: VLD=%b FRM=%b NOM=%0d WORD=%h want VLD=1 FRM=%b NOM=%0d WORD=%h",
                     tag, wi, bus.VLD, bus.FRM, bus.NOM, bus.WORD, (wi == 15), wi, w);
          end
        end
      end
    end
    n_checks++;
    if (vld_cnt != 16) begin n_fail++; $display("FAIL %s VLD count: got %0d want 16", tag, vld_cnt); end
    n_checks++;
    if (frm_cnt != 1) begin n_fail++; $display("FAIL %s FRM count: got %0d want 1", tag, frm_cnt); end
    n_checks++;
    if (frm_at != 64 + pause_len) begin
      n_fail++;
      $display("FAIL %s FRM position: got edge %0d want %0d", tag, frm_at, 64 + pause_len);
    end
    n_checks++;
    if (bus.CHK !== chk_exp) begin n_fail++; $display("FAIL %s CHK: got %h want %h", tag, bus.CHK, chk_exp); end
    n_checks++;
    if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL %s BUSY after frame: got %b want 0", tag, bus.BUSY); end
  endtask

  task automatic test_full_frame();
    run_frame(0, -1, 0, "full");
  endtask

  task automatic test_pause();
    run_frame(1, 7, 3, "pause");
  endtask

  task automatic test_back_to_back();
    run_frame(0, -1, 0, "b2b_a");
    run_frame(2, -1, 0, "b2b_b");
  endtask

  // Frame of pattern 0 up to bit 2 of word 9, then a new frame whose word 0 is 0xC.
  task automatic test_restart();
    logic [3:0] nw = 4'hC;
    for (int wi = 0; wi < 10; wi++) begin
      for (int b = 0; b < 4; b++) begin
        if (wi == 9 && b == 2) break;
        send_bit(wi == 0 && b == 0, 1'b1, 1'((wi >> b) & 1));
      end
    end
    for (int b = 0; b < 4; b++) begin
      send_bit(b == 0, 1'b1, nw[b]);
      if (b < 3) begin
        n_checks++;
        if (bus.VLD !== 1'b0 || bus.CHK !== 4'h9) begin
          n_fail++;
          $display("FAIL restart bit %0d: VLD=%b CHK=%h want VLD=0 CHK=9", b, bus.VLD, bus.CHK);
        end
      end
    end
    n_checks++;
    if ({bus.VLD, bus.FRM, bus.NOM, bus.WORD, bus.CHK} !== {1'b1, 1'b0, 4'd0, 4'hC, 4'h9}) begin
      n_fail++;
      $display("FAIL restart word: VLD=%b FRM=%b NOM=%0d WORD=%h CHK=%h want 1 0 0 c 9",
               bus.VLD, bus.FRM, bus.NOM, bus.WORD, bus.CHK);
    end
  endtask

  // start on the last bit of word 15: that word and the frame are dropped.
  task automatic test_priority();
    logic [3:0] nw = 4'h5;
    for (int wi = 0; wi < 16; wi++) begin
      for (int b = 0; b < 4; b++) begin
        if (wi == 15 && b == 3) break;
        send_bit(wi == 0 && b == 0, 1'b1, 1'((wi >> b) & 1));
      end
    end
    send_bit(1'b1, 1'b1, nw[0]);
    n_checks++;
    if ({bus.VLD, bus.FRM, bus.BUSY, bus.CHK} !== {1'b0, 1'b0, 1'b1, 4'h9}) begin
      n_fail++;
      $display("FAIL priority edge: VLD=%b FRM=%b BUSY=%b CHK=%h want 0 0 1 9", bus.VLD, bus.FRM, bus.BUSY, bus.CHK);
    end
    for (int b = 1; b < 4; b++) begin
      send_bit(1'b0, 1'b1, nw[b]);
      if (b < 3) begin
        n_checks++;
        if (bus.VLD !== 1'b0 || bus.FRM !== 1'b0) begin
          n_fail++;
          $display("FAIL priority bit %0d: VLD=%b FRM=%b want 0 0", b, bus.VLD, bus.FRM);
        end
      end
    end
    n_checks++;
    if ({bus.VLD, bus.FRM, bus.NOM, bus.WORD} !== {1'b1, 1'b0, 4'd0, 4'h5}) begin
      n_fail++;
      $display("FAIL priority next word: VLD=%b FRM=%b NOM=%0d WORD=%h want 1 0 0 5",
               bus.VLD, bus.FRM, bus.NOM, bus.WORD);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] w1 = 4'h3;
    logic [3:0] w2 = 4'h6;
    int         vld_cnt = 0;
    int         busy_cnt = 0;
    for (int b = 0; b < 4; b++) send_bit(1'b0, 1'b1, w1[b]);
    n_checks++;
    if ({bus.VLD, bus.NOM, bus.WORD} !== {1'b1, 4'd1, 4'h3}) begin
      n_fail++;
      $display("FAIL pre-reset word: VLD=%b NOM=%0d WORD=%h want 1 1 3", bus.VLD, bus.NOM, bus.WORD);
    end
    #2;
    clr = 1'b0;
    #1;
    n_checks++;
    if ({bus.VLD, bus.FRM, bus.BUSY, bus.NOM, bus.WORD, bus.CHK} !== '0) begin
      n_fail++;
      $display("FAIL async clear: VLD=%b FRM=%b BUSY=%b NOM=%0d WORD=%h CHK=%h want all 0",
               bus.VLD, bus.FRM, bus.BUSY, bus.NOM, bus.WORD, bus.CHK);
    end
    #2;
    clr = 1'b1;
    send_bit(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL start without en: BUSY=%b want 0", bus.BUSY); end
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 1'b1, 1'b1);
      if (bus.VLD === 1'b1) vld_cnt++;
      if (bus.BUSY === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (vld_cnt != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL no start after reset: VLD cycles=%0d BUSY cycles=%0d want 0 0", vld_cnt, busy_cnt);
    end
    for (int b = 0; b < 4; b++) send_bit(b == 0, 1'b1, w2[b]);
    n_checks++;
    if ({bus.VLD, bus.NOM, bus.WORD} !== {1'b1, 4'd0, 4'h6}) begin
      n_fail++;
      $display("FAIL first word after reset: VLD=%b NOM=%0d WORD=%h want 1 0 6", bus.VLD, bus.NOM, bus.WORD);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_pause();
    test_back_to_back();
    test_restart();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Downstream stage of the ROM serial transmitter. It consumes the 1-bit TX stream, which carries 16 words × 4 bits, LSB first, one bit per hit edge.
- It reassembles each 4-bit word, reports the word and its index, and pulses at frame end.
- It also produces an XOR checksum of the frame for comparison against the ROM contents.
- It runs on the same hit clock as the transmitter counter.

Parameters:
- WIDTH, 4, bits per word; the bit counter is clog2(WIDTH) wide.
- WORDS, 16, words per frame; the index counter is clog2(WORDS) wide.

Ports:
- hit  input  1  clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  frame-align strobe; the rx bit in the same cycle is bit 0 of word 0.
- en  input  1  sample enable; when low, rx is ignored and all state holds.
- rx  input  1  serial data (transmitter TX), LSB first.
- WORD  output  WIDTH  last completed word.
- NOM  output  clog2(WORDS)  index of the word in WORD.
- VLD  output  1  one-cycle pulse; WORD/NOM updated this cycle.
- FRM  output  1  one-cycle pulse, coincident with the VLD of word WORDS-1.
- CHK  output  WIDTH  XOR of all words of the last completed frame.
- BUSY  output  1  high in RECV state.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; the shift register, bit counter, word counter and running XOR are 0. All outputs are 0: WORD=0, NOM=0, VLD=0, FRM=0, CHK=0, BUSY=0.
- All outputs are registered. WORD, NOM and CHK hold their value between updates.
- State IDLE:
  - start=1 and en=1: sample rx as bit 0 of word 0, set bitcnt=1, wordcnt=0, xor=0, go to RECV.
  - start=1 with en=0: ignored.
  - rx is ignored otherwise.
- State RECV, each edge with en=1:
  - Shift: sh <= {rx, sh[WIDTH-1:1]}, bitcnt++.
  - When bitcnt==WIDTH-1, the word completes:
    - WORD <= {rx, sh[WIDTH-1:1]}; NOM <= wordcnt; VLD=1 next cycle.
    - xor <= xor ^ word; bitcnt <= 0; wordcnt++.
  - When the completed word has wordcnt==WORDS-1:
    - CHK <= xor ^ word; FRM=1 together with VLD.
    - wordcnt wraps to 0; go to IDLE.
- State RECV, en=0: full hold. Counters and the partial word are frozen, no pulses are generated, and the bit resumes on the next en=1 edge.
- start=1 with en=1 while in RECV: restart. The partial word and frame are discarded with no VLD/FRM. The current rx becomes bit 0 of word 0; bitcnt=1, wordcnt=0, xor=0. CHK and WORD keep their old values.
  - start has priority even on the final bit of a frame: no VLD/FRM is generated for that word.
- Latency: WORD/VLD appear 1 cycle after the edge that samples the final (MSB) bit.
- Back-to-back frames: with start asserted on the bit-0 cycle of every frame, there is no gap. A continuous 64-cycle transmitter loop needs start once per 64 cycles.
- VLD and FRM are never asserted while clr=0. Reset mid-frame discards everything; the first VLD after reset requires a new start.

Test Plan:
- Reset values: hold clr=0, then release → WORD=0, NOM=0, CHK=0, VLD=0, FRM=0, BUSY=0. Asserting clr=0 mid-frame clears outputs immediately, with no clock edge needed.
- Single word: start on the first bit, rx=0,1,0,1 (0xA, LSB first), en=1 → after the 4th edge, WORD=0xA, NOM=0, VLD high for exactly 1 cycle, BUSY=1.
- Full frame: words 0x0..0xF serialized LSB first over 64 cycles → 16 VLD pulses with NOM=0..15. FRM only with NOM=15, CHK=0x0 (XOR of 0..15), BUSY=0 afterwards.
- Pause: frame of all 0x5 with en=0 for 3 cycles inserted mid-word 7 → words are still 0x5 and NOMs are contiguous. There are no VLD during the pause, and the FRM position is shifted by 3 cycles.
- Restart: start reasserted at bit 2 of word 9 → no VLD for word 9, and the next VLD has NOM=0 four sampled bits later. CHK is unchanged until the new frame completes.
- Priority corner: start on the last bit of word 15 → no FRM, no VLD. The next VLD reports NOM=0.
